// File: rtl/mem_req_demux.sv
// One-to-two memory request demux: routes requests by address and returns
// responses to the core in issue order using an in-order tag FIFO.
module mem_req_demux #(
  parameter logic [31:0] SPLIT_ADDR = 32'h8000_0000,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        d0_req_valid,
  input  logic        d0_req_ready,
  output logic [31:0] d0_req_addr,
  output logic        d0_req_we,
  output logic [31:0] d0_req_wdata,
  input  logic        d0_rsp_valid,
  output logic        d0_rsp_ready,
  input  logic [31:0] d0_rsp_rdata,
  output logic        d1_req_valid,
  input  logic        d1_req_ready,
  output logic [31:0] d1_req_addr,
  output logic        d1_req_we,
  output logic [31:0] d1_req_wdata,
  input  logic        d1_rsp_valid,
  output logic        d1_rsp_ready,
  input  logic [31:0] d1_rsp_rdata
);

  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [MAX_OUT-1:0] r_tags;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_err;

  logic w_sel;
  logic w_can_issue;
  logic w_nonempty;
  logic w_head;
  logic w_push;
  logic w_pop;

  assign w_sel       = (req_addr >= SPLIT_ADDR);
  assign w_can_issue = (r_count < CW'(MAX_OUT));
  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_tags[r_rptr];

  // Request path: combinational steer by address
  assign d0_req_valid = req_valid & w_can_issue & ~w_sel & ~rst;
  assign d1_req_valid = req_valid & w_can_issue &  w_sel & ~rst;
  assign req_ready    = w_can_issue & (w_sel ? d1_req_ready : d0_req_ready) & ~rst;

  assign d0_req_addr  = req_addr;
  assign d0_req_we    = req_we;
  assign d0_req_wdata = req_wdata;
  assign d1_req_addr  = req_addr;
  assign d1_req_we    = req_we;
  assign d1_req_wdata = req_wdata;

  // Response path: only the head-of-line responder is visible to the core
  assign rsp_valid    = w_nonempty & (w_head ? d1_rsp_valid : d0_rsp_valid) & ~rst;
  assign rsp_rdata    = w_head ? d1_rsp_rdata : d0_rsp_rdata;
  assign d0_rsp_ready = w_nonempty & ~w_head & rsp_ready & ~rst;
  assign d1_rsp_ready = w_nonempty &  w_head & rsp_ready & ~rst;

  assign w_push = req_valid & req_ready;
  assign w_pop  = rsp_valid & rsp_ready;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // Any responder activity with nothing outstanding is a protocol violation
      if (!w_nonempty && (d0_rsp_valid || d1_rsp_valid)) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset; entries are only read while count > 0
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wptr] <= w_sel;
  end

endmodule
